// File: rtl/hunter_packet_tx.sv
// Frame serialiser for the fan-controller RF link: preamble zeros, device ID, command,
// each bit sent LSB first as low/data/high phases, with optional repeats and idle gaps.
//
// state  | meaning
// -------+------------------------------------------------
// S_IDLE | line low, ready for a new request
// S_SEND | frame bits in flight (phase 0 low, 1 data, 2 high)
// S_GAP  | line low for GAP_PHASES phases after each frame
module hunter_packet_tx #(
   parameter int PHASE_DIV     = 1836,
   parameter int PREAMBLE_BITS = 2,
   parameter int ID_WIDTH      = 4,
   parameter int CMD_WIDTH     = 7,
   parameter int REPEAT_WIDTH  = 3,
   parameter int GAP_PHASES    = 3
) (
   input  logic                    ref_clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ID_WIDTH-1:0]     id,
   input  logic [CMD_WIDTH-1:0]    cmd_code,
   input  logic [REPEAT_WIDTH-1:0] repeats,
   output logic                    ready,
   output logic                    busy,
   output logic                    done,
   output logic                    out
);

   localparam int N  = PREAMBLE_BITS + ID_WIDTH + CMD_WIDTH;
   localparam int PW = $clog2(PHASE_DIV);
   localparam int BW = $clog2(N + 1);
   localparam int GW = (GAP_PHASES > 1) ? $clog2(GAP_PHASES) : 1;

   localparam logic [PW-1:0] PH_LOAD  = PW'(PHASE_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_PHASES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t                  state, state_n;
   logic [PW-1:0]           phase_cnt, phase_cnt_n;
   logic [1:0]              sub, sub_n;
   logic [BW-1:0]           bit_idx, bit_idx_n;
   logic [GW-1:0]           gap_cnt, gap_cnt_n;
   logic [REPEAT_WIDTH-1:0] rep_cnt, rep_cnt_n;
   logic [N-1:0]            shadow, shadow_n;
   logic                    out_n, done_n;
   logic                    tc;

   assign ready = (state == S_IDLE) && !reset;
   assign busy  = (state != S_IDLE);
   assign tc    = (phase_cnt == '0);

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state     <= S_IDLE;
         phase_cnt <= '0;
         sub       <= '0;
         bit_idx   <= '0;
         gap_cnt   <= '0;
         rep_cnt   <= '0;
         shadow    <= '0;
         out       <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         phase_cnt <= phase_cnt_n;
         sub       <= sub_n;
         bit_idx   <= bit_idx_n;
         gap_cnt   <= gap_cnt_n;
         rep_cnt   <= rep_cnt_n;
         shadow    <= shadow_n;
         out       <= out_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n     = state;
      phase_cnt_n = phase_cnt;
      sub_n       = sub;
      bit_idx_n   = bit_idx;
      gap_cnt_n   = gap_cnt;
      rep_cnt_n   = rep_cnt;
      shadow_n    = shadow;
      case (state)
         S_IDLE: begin
            if (start && ready) begin
               state_n     = S_SEND;
               phase_cnt_n = PH_LOAD;
               sub_n       = 2'd0;
               bit_idx_n   = '0;
               rep_cnt_n   = repeats;
               shadow_n    = N'({cmd_code, id}) << PREAMBLE_BITS;
            end
         end
         S_SEND: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (tc) begin
               phase_cnt_n = PH_LOAD;
               if (sub == 2'd2) begin
                  sub_n = 2'd0;
                  if (bit_idx == LAST_BIT) begin
                     state_n   = S_GAP;
                     gap_cnt_n = GAP_LOAD;
                  end else begin
                     bit_idx_n = bit_idx + 1'b1;
                  end
               end else begin
                  sub_n = sub + 1'b1;
               end
            end else begin
               phase_cnt_n = phase_cnt - 1'b1;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (tc) begin
               phase_cnt_n = PH_LOAD;
               if (gap_cnt == '0) begin
                  if (rep_cnt != '0) begin
                     rep_cnt_n = rep_cnt - 1'b1;
                     state_n   = S_SEND;
                     sub_n     = 2'd0;
                     bit_idx_n = '0;
                  end else begin
                     state_n = S_IDLE;
                  end
               end else begin
                  gap_cnt_n = gap_cnt - 1'b1;
               end
            end else begin
               phase_cnt_n = phase_cnt - 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // out is computed from the next-state values so the flop shows the new phase on the edge it starts
   always_comb begin
      out_n  = 1'b0;
      done_n = (state == S_GAP) && (state_n == S_IDLE) && !abort;
      if (state_n == S_SEND) begin
         case (sub_n)
            2'd0:    out_n = 1'b0;
            2'd1:    out_n = shadow_n[bit_idx_n];
            default: out_n = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_hunter_packet_tx.sv
// Directed bench for hunter_packet_tx with PHASE_DIV=4: 156-cycle frames, 12-cycle gaps.
module tb_hunter_packet_tx;

   logic       ref_clk, reset, start, abort;
   logic [3:0] id;
   logic [6:0] cmd_code;
   logic [2:0] repeats;
   logic       ready, busy, done, out;

   int passed = 0;
   int total  = 0;
   logic cap [0:511];
   int bad_out, bad_busy, dones;
   logic [12:0] dec;

   localparam logic [12:0] BITS_A = 13'b1001111101000;  // id=1010, cmd=1001111
   localparam logic [12:0] BITS_B = 13'b0000001011000;  // id=0110, cmd=0000001

   hunter_packet_tx #(.PHASE_DIV(4)) dut (
      .ref_clk(ref_clk), .reset(reset), .start(start), .abort(abort),
      .id(id), .cmd_code(cmd_code), .repeats(repeats),
      .ready(ready), .busy(busy), .done(done), .out(out)
   );

   initial begin
      ref_clk = 1'b0;
      forever #5 ref_clk = ~ref_clk;
   end

   task automatic step();
      @(posedge ref_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic exp_out(input logic [12:0] b, input int k);
      int p, ph;
      p = k % 168;
      if (p >= 156) return 1'b0;
      ph = (p % 12) / 4;
      if (ph == 0) return 1'b0;
      if (ph == 1) return b[p / 12];
      return 1'b1;
   endfunction

   // Samples len cycles starting at the current one; optionally pulses start with a new cmd at ign_at.
   task automatic capture(input int len, input logic [12:0] b, input int ign_at);
      bad_out = 0; bad_busy = 0; dones = 0;
      for (int i = 0; i < len; i++) begin
         cap[i] = out;
         if (out !== exp_out(b, i)) bad_out++;
         if (busy !== 1'b1) bad_busy++;
         if (done !== 1'b0) dones++;
         if (i == ign_at) begin
            start = 1'b1;
            cmd_code = 7'b0110000;
         end else if (i == ign_at + 1) begin
            start = 1'b0;
         end
         step();
      end
   endtask

   task automatic decode();
      for (int b = 0; b < 13; b++) dec[b] = cap[12*b + 5];
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      id = '0; cmd_code = '0; repeats = '0;

      // reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_outputs", {out, busy, done, ready}, 4'b0000);
      end
      reset = 1'b0;
      step();
      check("ready_after_reset", {ready, busy}, 2'b10);

      // single frame
      id = 4'b1010; cmd_code = 7'b1001111; repeats = 3'd0; start = 1'b1;
      step();
      start = 1'b0;
      check("s1_accept", {busy, ready, out}, 3'b100);
      capture(168, BITS_A, -1);
      decode();
      check("s1_bits", dec, BITS_A);
      check("s1_wave", bad_out, 0);
      check("s1_busy", bad_busy, 0);
      check("s1_early_done", dones, 0);
      check("s1_done", {done, ready, busy, out}, 4'b1100);
      step();
      check("s1_done_pulse", {done, ready}, 2'b01);

      // three frames
      repeats = 3'd2; start = 1'b1;
      step();
      start = 1'b0;
      capture(504, BITS_A, -1);
      check("rep_wave", bad_out, 0);
      check("rep_busy", bad_busy, 0);
      check("rep_early_done", dones, 0);
      check("rep_done", {done, busy}, 2'b10);
      step();

      // start mid-frame with a different cmd is ignored
      repeats = 3'd0; cmd_code = 7'b1001111; start = 1'b1;
      step();
      start = 1'b0;
      capture(168, BITS_A, 50);
      check("ign_wave", bad_out, 0);
      check("ign_busy", bad_busy, 0);
      check("ign_done", done, 1'b1);
      for (int i = 0; i < 6; i++) step();
      check("ign_no_extra", {busy, ready, out}, 3'b010);

      // abort together with start at cycle 70 of a two-frame job
      id = 4'b1010; cmd_code = 7'b1001111; repeats = 3'd1; start = 1'b1;
      step();
      start = 1'b0;
      capture(70, BITS_A, -1);
      check("abort_pre_wave", bad_out, 0);
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0;
      check("abort_idle", {out, busy, done, ready}, 4'b0001);
      repeats = 3'd0;
      step();
      start = 1'b0;
      check("abort_restart", {busy, ready, out, done}, 4'b1000);
      capture(168, BITS_A, -1);
      check("restart_wave", bad_out, 0);
      check("restart_done", done, 1'b1);

      // back-to-back start on the done cycle
      id = 4'b0110; cmd_code = 7'b0000001; start = 1'b1;
      step();
      start = 1'b0;
      check("b2b_accept", {busy, ready, out, done}, 4'b1000);
      capture(100, BITS_B, -1);
      check("b2b_wave", bad_out, 0);
      check("b2b_busy", bad_busy, 0);

      // reset in mid-frame
      reset = 1'b1;
      step();
      check("midreset", {out, busy, done, ready}, 4'b0000);
      reset = 1'b0;
      step();
      check("midreset_release", {out, busy, done, ready}, 4'b0001);
      for (int i = 0; i < 200; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) break;
         step();
      end
      check("midreset_quiet", {busy, done}, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
